// File: rtl/intr_claim_arb.sv
// rtl/intr_claim_arb.sv - single-target interrupt arbiter with claim/complete handshake
// Optional feature macro: INTR_CLAIM_ARB_RR_EN (round-robin arbitration instead of fixed priority).
module intr_claim_arb #(
    parameter int NumSrc = 8,
    parameter int IdW    = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] intr_src_i,
    input  logic [NumSrc-1:0] mask_i,
    input  logic              claim_i,
    input  logic              complete_i,
    input  logic [IdW-1:0]    complete_id_i,
    output logic              irq_o,
    output logic [IdW-1:0]    claim_id_o,
    output logic              busy_o,
    output logic [NumSrc-1:0] pending_o,
    output logic              err_o
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StNotify  = 2'd1;
    localparam logic [1:0] StClaimed = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [NumSrc-1:0] pending_q, pending_d;
    logic [NumSrc-1:0] in_svc_q, in_svc_d;
    logic [NumSrc-1:0] req, sel_oh, claim_clr;
    logic [IdW-1:0]    claim_id_q, claim_id_d, win_id;
    logic              err_q, err_d;

    assign req    = pending_q & mask_i;
    assign sel_oh = {{(NumSrc-1){1'b0}}, 1'b1} << claim_id_q;

`ifdef INTR_CLAIM_ARB_RR_EN
    logic [IdW-1:0]      rr_ptr_q;
    logic [2*NumSrc-1:0] req_rot_dbl;
    logic [NumSrc-1:0]   req_rot;
    logic [IdW-1:0]      rot_off;
    logic [IdW:0]        rr_sum;

    // Rotate requests so the search always begins at bit 0, then map the offset back.
    assign req_rot_dbl = {req, req} >> rr_ptr_q;
    assign req_rot     = req_rot_dbl[NumSrc-1:0];

    always_comb begin
        rot_off = '0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_off = IdW'(i);
            end
        end
        rr_sum = {1'b0, rr_ptr_q} + {1'b0, rot_off};
        if (rr_sum >= (IdW+1)'(NumSrc)) begin
            rr_sum = rr_sum - (IdW+1)'(NumSrc);
        end
        win_id = rr_sum[IdW-1:0];
    end

    // Pointer moves only on an accepted claim, never on a mask withdrawal.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (state_q == StNotify && claim_i) begin
            if ({1'b0, claim_id_q} == (IdW+1)'(NumSrc - 1)) begin
                rr_ptr_q <= '0;
            end else begin
                rr_ptr_q <= claim_id_q + 1'b1;
            end
        end
    end
`else
    always_comb begin
        win_id = '0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id = IdW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        claim_id_d = claim_id_q;
        in_svc_d   = in_svc_q;
        claim_clr  = '0;
        err_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d    = StNotify;
                    claim_id_d = win_id;
                end
                if (claim_i || complete_i) begin
                    err_d = 1'b1;
                end
            end
            StNotify: begin
                if (claim_i) begin
                    claim_clr = sel_oh;
                    in_svc_d  = in_svc_q | sel_oh;
                    state_d   = StClaimed;
                end else if (!(|(mask_i & sel_oh))) begin
                    state_d = StIdle;
                end
                if (complete_i) begin
                    err_d = 1'b1;
                end
            end
            StClaimed: begin
                if (complete_i) begin
                    if (complete_id_i == claim_id_q) begin
                        in_svc_d = in_svc_q & ~sel_oh;
                        state_d  = StIdle;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (claim_i) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Gating on the next in-service value lets a held level re-pend the cycle after completion.
        pending_d = (pending_q & ~claim_clr) | (intr_src_i & ~in_svc_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            in_svc_q   <= '0;
            claim_id_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            in_svc_q   <= in_svc_d;
            claim_id_q <= claim_id_d;
            err_q      <= err_d;
        end
    end

    assign irq_o      = (state_q == StNotify);
    assign busy_o     = (state_q == StClaimed);
    assign claim_id_o = (state_q == StIdle) ? '0 : claim_id_q;
    assign pending_o  = pending_q;
    assign err_o      = err_q;

endmodule
